// File: rtl/async_fifo_gptr_receiver.sv
// async_fifo_gptr_receiver
// Read-domain receiver for the Gray pointer of an asynchronous FIFO.
// It synchronizes the write-side Gray pointer through a flop chain and
// decodes it to binary. It then derives empty, occupancy level and
// almost_empty from the synchronized pointer and the local Gray pointer.
// Optional feature macro: ASYNC_FIFO_GRAY_CHECK_EN. When it is defined, the
// block adds a sticky Gray-protocol violation flag (gray_err). When it is
// undefined, gray_err is tied low and the extra flops are not built.
module async_fifo_gptr_receiver #(
    parameter int COUNTER_BITS        = 4,
    parameter int SYNC_STAGES         = 2,
    parameter int ALMOST_EMPTY_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [COUNTER_BITS-1:0] remote_gptr,
    input  logic [COUNTER_BITS-1:0] local_gptr,
    output logic [COUNTER_BITS-1:0] remote_bptr_sync,
    output logic                    empty,
    output logic [COUNTER_BITS-1:0] level,
    output logic                    almost_empty,
    output logic                    gray_err
);

    localparam logic [COUNTER_BITS-1:0] DEPTH    = COUNTER_BITS'(1 << (COUNTER_BITS - 1));
    localparam logic [COUNTER_BITS-1:0] THRESH_V = COUNTER_BITS'(ALMOST_EMPTY_THRESH);

    function automatic logic [COUNTER_BITS-1:0] gray2bin(input logic [COUNTER_BITS-1:0] g);
        logic [COUNTER_BITS-1:0] b;
        b[COUNTER_BITS-1] = g[COUNTER_BITS-1];
        for (int i = COUNTER_BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [COUNTER_BITS-1:0] r_sync [SYNC_STAGES];
    logic [COUNTER_BITS-1:0] r_level;
    logic                    r_almost_empty;
    logic [COUNTER_BITS-1:0] w_sync_g;
    logic [COUNTER_BITS-1:0] w_local_b;
    logic [COUNTER_BITS-1:0] w_next_level;

    // Shift the remote Gray pointer through the synchronizer chain.
    // NOTE: every stage is reset explicitly. This is a small flop chain, not a RAM, so an async reset costs nothing and keeps the outputs defined.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample its predecessor's old value, so the chain shifts by exactly one per edge.
            r_sync[0] <= remote_gptr;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_g         = r_sync[SYNC_STAGES-1];
    assign remote_bptr_sync = gray2bin(w_sync_g);
    assign w_local_b        = gray2bin(local_gptr);
    // Wrap-around falls out of the modulo-2^N subtraction.
    assign w_next_level     = remote_bptr_sync - w_local_b;

    // Register the occupancy and its almost-empty flag together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level        <= '0;
            r_almost_empty <= 1'b1;
        end else begin
            r_level        <= w_next_level;
            r_almost_empty <= (w_next_level <= THRESH_V);
        end
    end

    // empty is unregistered so that a read catching up asserts it at once.
    // The reset term keeps empty high while reset is held, whatever the
    // value of local_gptr.
    assign empty        = reset | (w_sync_g == local_gptr);
    assign level        = r_level;
    assign almost_empty = r_almost_empty;

`ifdef ASYNC_FIFO_GRAY_CHECK_EN
    logic [COUNTER_BITS-1:0] r_prev_g;
    logic                    r_cmp_en;
    logic                    r_gray_err;
    logic [COUNTER_BITS-1:0] w_diff;
    logic                    w_multi_bit;

    assign w_diff      = w_sync_g ^ r_prev_g;
    // Clearing the lowest set bit leaves a nonzero value when more than one bit changed.
    assign w_multi_bit = (w_diff & (w_diff - 1'b1)) != '0;

    // Track the previous synchronized pointer and latch any protocol violation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_g   <= '0;
            r_cmp_en   <= 1'b0;
            r_gray_err <= 1'b0;
        end else begin
            r_prev_g <= w_sync_g;
            r_cmp_en <= 1'b1;
            if (r_cmp_en && (w_multi_bit || (w_next_level > DEPTH))) begin
                r_gray_err <= 1'b1;
            end
        end
    end

    assign gray_err = r_gray_err;
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_gptr_receiver.sv
// tb_async_fifo_gptr_receiver
// Directed bench for async_fifo_gptr_receiver with COUNTER_BITS=4,
// SYNC_STAGES=2 and ALMOST_EMPTY_THRESH=1. The expected values are worked
// out by hand from the Gray/binary tables and the pipeline latency.
module tb_async_fifo_gptr_receiver;

    logic       clk;
    logic       reset;
    logic [3:0] remote_gptr;
    logic [3:0] local_gptr;
    logic [3:0] remote_bptr_sync;
    logic       empty;
    logic [3:0] level;
    logic       almost_empty;
    logic       gray_err;

    int n_checks;
    int n_errors;

    async_fifo_gptr_receiver #(
        .COUNTER_BITS       (4),
        .SYNC_STAGES        (2),
        .ALMOST_EMPTY_THRESH(1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .remote_gptr     (remote_gptr),
        .local_gptr      (local_gptr),
        .remote_bptr_sync(remote_bptr_sync),
        .empty           (empty),
        .level           (level),
        .almost_empty    (almost_empty),
        .gray_err        (gray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ASYNC_FIFO_GRAY_CHECK_EN
    localparam logic GRAY_ERR_EXP = 1'b1;
`else
    localparam logic GRAY_ERR_EXP = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step 1 ns past it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulse reset with both pointers at zero, then release it on the clock grid.
    task automatic do_reset();
        #2;
        reset       = 1'b1;
        remote_gptr = 4'b0000;
        local_gptr  = 4'b0000;
        ticks(2);
        reset = 1'b0;
        ticks(2);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        remote_gptr = 4'b0000;
        local_gptr  = 4'b0000;
        ticks(2);
        reset = 1'b0;
        ticks(2);

        // Load some occupancy, then assert reset mid-clock.
        remote_gptr = 4'b0110;             // bin 4
        ticks(4);
        check("pre_rst_level", level, 4);
        check("pre_rst_empty", empty, 0);
        #2;
        reset = 1'b1;                       // asserted between clock edges
        #1;
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_bptr", remote_bptr_sync, 0);
        check("rst_gerr", gray_err, 0);
        tick();
        remote_gptr = 4'b0000;
        tick();
        reset = 1'b0;
        ticks(3);
        check("idle_empty", empty, 1);
        check("idle_level", level, 0);

        // Single write: empty drops after exactly two edges, level follows one edge later.
        remote_gptr = 4'b0001;
        tick();
        check("sw_empty_e1", empty, 1);
        tick();
        check("sw_empty_e2", empty, 0);
        check("sw_bptr_e2", remote_bptr_sync, 1);
        check("sw_level_e2", level, 0);
        tick();
        check("sw_level_e3", level, 1);
        check("sw_ae_e3", almost_empty, 1);

        // Fill to full depth by stepping through Gray codes 2..8.
        remote_gptr = 4'b0011; tick();
        remote_gptr = 4'b0010; tick();
        remote_gptr = 4'b0110; tick();
        remote_gptr = 4'b0111; tick();
        remote_gptr = 4'b0101; tick();
        remote_gptr = 4'b0100; tick();
        remote_gptr = 4'b1100; ticks(3);
        check("full_level", level, 8);
        check("full_ae", almost_empty, 0);
        check("full_empty", empty, 0);
        check("full_bptr", remote_bptr_sync, 8);

        // Wrap: both pointers start at binary 15, then remote advances to binary 0.
        do_reset();
        remote_gptr = 4'b1000;
        local_gptr  = 4'b1000;
        ticks(3);
        check("wrap_bptr15", remote_bptr_sync, 15);
        check("wrap_empty0", empty, 1);
        check("wrap_level0", level, 0);
        remote_gptr = 4'b0000;
        tick();
        check("wrap_empty_e1", empty, 1);
        tick();
        check("wrap_empty_e2", empty, 0);
        check("wrap_bptr0", remote_bptr_sync, 0);
        check("wrap_level_e2", level, 0);
        tick();
        check("wrap_level_e3", level, 1);
        check("wrap_ae_e3", almost_empty, 1);

        // Read catch-up: synchronized remote at binary 3, local moves 2 -> 3.
        do_reset();
        remote_gptr = 4'b0010;             // bin 3
        ticks(3);
        check("cu_level3", level, 3);
        check("cu_ae3", almost_empty, 0);
        local_gptr = 4'b0011;              // bin 2
        tick();
        check("cu_level1", level, 1);
        check("cu_empty_before", empty, 0);
        local_gptr = 4'b0010;              // bin 3
        #1;
        check("cu_empty_same", empty, 1);
        tick();
        check("cu_level0", level, 0);
        check("cu_ae0", almost_empty, 1);

        // Illegal two-bit jump on the remote Gray pointer.
        do_reset();
        check("ge_clear", gray_err, 0);
        remote_gptr = 4'b0011;
        ticks(3);
        check("ge_set", gray_err, GRAY_ERR_EXP);
        ticks(4);
        check("ge_sticky", gray_err, GRAY_ERR_EXP);
        #2;
        reset = 1'b1;
        #1;
        check("ge_rst", gray_err, 0);
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety bound so the bench can never hang.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
